// File: rtl/star_pkg.sv
// Shared types and width helpers for the STAR softmax row controller.
package star_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CAMSUB  = 3'd2,
        S_FINDMAX = 3'd3,
        S_FINDSUB = 3'd4,
        S_ACCUM   = 3'd5,
        S_EMIT    = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    // CNT_W: width able to hold a full column popcount (0..INPUT_LEN).
    function automatic int cnt_w(input int input_len);
        return $clog2(input_len + 1);
    endfunction

    // ROW_W: width able to hold the completed-row count (0..NUM_ROWS).
    function automatic int row_w(input int num_rows);
        return $clog2(num_rows + 1);
    endfunction

endpackage

// File: rtl/star_col_counter.sv
// Column popcount over INPUT_LEN match vectors, narrowed to SUM_W bits per entry.
// STAR_SUM_SAT_EN selects saturation at 2^SUM_W-1; otherwise counts wrap.
module star_col_counter
    import star_pkg::*;
#(
    parameter int INPUT_LEN = 16,
    parameter int LUT_LEN   = 64,
    parameter int SUM_W     = 3
) (
    input  logic [INPUT_LEN*LUT_LEN-1:0] mv_flat,
    output logic [LUT_LEN*SUM_W-1:0]     cnt
);

    localparam int CNT_W = cnt_w(INPUT_LEN);
`ifdef STAR_SUM_SAT_EN
    localparam int unsigned SAT_MAX = (1 << SUM_W) - 1;
`endif

    logic [CNT_W-1:0] pc;

    always_comb begin
        cnt = '0;
        pc  = '0;
        for (int j = 0; j < LUT_LEN; j++) begin
            pc = '0;
            for (int k = 0; k < INPUT_LEN; k++) begin
                pc = pc + CNT_W'(mv_flat[k*LUT_LEN + j]);
            end
`ifdef STAR_SUM_SAT_EN
            if (32'(pc) > SAT_MAX) cnt[j*SUM_W +: SUM_W] = SUM_W'(SAT_MAX);
            else                   cnt[j*SUM_W +: SUM_W] = SUM_W'(pc);
`else
            cnt[j*SUM_W +: SUM_W] = SUM_W'(pc);
`endif
        end
    end

endmodule

// File: rtl/star_softmax_ctrl.sv
// STAR CAM/LUT softmax row controller: load, CAM lookup, max search, subtract,
// column accumulate, and stream beats. Optional STAR_SUM_SAT_EN saturates counts.
module star_softmax_ctrl
    import star_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int INPUT_LEN = 16,
    parameter int LUT_LEN   = 64,
    parameter int NUM_ROWS  = 16,
    parameter int ADDR_W    = 9,
    parameter int SUM_W     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     data_req,
    output logic [ADDR_W-1:0]        data_addr,
    input  logic                     data_vld,
    input  logic [DATA_W-1:0]        data,
    output logic                     cam_req,
    output logic [DATA_W-1:0]        xi,
    input  logic                     cam_ack,
    input  logic [LUT_LEN-1:0]       i_xi_MV,
    output logic                     sub_req,
    output logic [LUT_LEN-1:0]       o_xmax_MV,
    output logic [LUT_LEN-1:0]       o_xi_MV,
    input  logic                     sub_ack,
    input  logic [LUT_LEN-1:0]       i_sub_MV,
    output logic                     mv_vld,
    input  logic                     mv_rdy,
    output logic [LUT_LEN-1:0]       o_sub_MV,
    output logic [LUT_LEN*SUM_W-1:0] o_sum_MV,
    output logic                     row_done,
    output logic                     busy,
    output logic                     finish,
    output state_t                   dbg_state
);

    localparam int K_W   = $clog2(INPUT_LEN);
    localparam int ROW_W = row_w(NUM_ROWS);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(INPUT_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    state_t                     state;
    logic [K_W-1:0]             k;
    logic [ROW_W-1:0]           row_cnt;
    logic [DATA_W-1:0]          row_buf [INPUT_LEN];
    logic [LUT_LEN-1:0]         mv_q    [INPUT_LEN];
    logic [LUT_LEN-1:0]         max_q;
    logic [LUT_LEN*SUM_W-1:0]   cnt_q;
    logic [LUT_LEN*SUM_W-1:0]   cnt_next;
    logic [INPUT_LEN*LUT_LEN-1:0] mv_flat;

    assign dbg_state = state;

    always_comb begin
        mv_flat = '0;
        for (int i = 0; i < INPUT_LEN; i++) mv_flat[i*LUT_LEN +: LUT_LEN] = mv_q[i];
    end

    star_col_counter #(
        .INPUT_LEN (INPUT_LEN),
        .LUT_LEN   (LUT_LEN),
        .SUM_W     (SUM_W)
    ) u_col_counter (
        .mv_flat (mv_flat),
        .cnt     (cnt_next)
    );

    // Handshakes: a req/vld is raised only when low, so every ack is followed by
    // at least one idle cycle, and an ack seen while req is low falls through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            k         <= '0;
            row_cnt   <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < INPUT_LEN; i++) begin
                row_buf[i] <= '0;
                mv_q[i]    <= '0;
            end
            data_req  <= 1'b0;
            data_addr <= '0;
            cam_req   <= 1'b0;
            xi        <= '0;
            sub_req   <= 1'b0;
            o_xmax_MV <= '0;
            o_xi_MV   <= '0;
            mv_vld    <= 1'b0;
            o_sub_MV  <= '0;
            o_sum_MV  <= '0;
            row_done  <= 1'b0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            row_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                        k     <= '0;
                    end
                end
                S_LOAD: begin
                    if (!data_req) begin
                        data_req <= 1'b1;
                    end else if (data_vld) begin
                        row_buf[k] <= data;
                        data_addr  <= data_addr + ADDR_W'(1);
                        data_req   <= 1'b0;
                        if (k == K_LAST) begin
                            k     <= '0;
                            cnt_q <= '0;
                            state <= S_CAMSUB;
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end
                end
                S_CAMSUB: begin
                    if (!cam_req) begin
                        cam_req <= 1'b1;
                        xi      <= row_buf[k];
                    end else if (cam_ack) begin
                        mv_q[k] <= i_xi_MV;
                        cam_req <= 1'b0;
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= S_FINDMAX;
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end
                end
                S_FINDMAX: begin
                    // Strict compare keeps the earliest index on ties.
                    if (k == '0 || mv_q[k] > max_q) max_q <= mv_q[k];
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= S_FINDSUB;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                S_FINDSUB: begin
                    if (!sub_req) begin
                        sub_req   <= 1'b1;
                        o_xmax_MV <= max_q;
                        o_xi_MV   <= mv_q[k];
                    end else if (sub_ack) begin
                        mv_q[k]   <= i_sub_MV;
                        sub_req   <= 1'b0;
                        o_xmax_MV <= '0;
                        o_xi_MV   <= '0;
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= S_ACCUM;
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end
                end
                S_ACCUM: begin
                    cnt_q <= cnt_next;
                    state <= S_EMIT;
                end
                S_EMIT: begin
                    if (!mv_vld) begin
                        mv_vld   <= 1'b1;
                        o_sub_MV <= mv_q[k];
                        o_sum_MV <= cnt_q;
                    end else if (mv_rdy) begin
                        mv_vld <= 1'b0;
                        if (k == K_LAST) begin
                            k        <= '0;
                            row_done <= 1'b1;
                            row_cnt  <= row_cnt + ROW_W'(1);
                            if (row_cnt == ROW_LAST) begin
                                state <= S_FIN;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_LOAD;
                            end
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end
                end
                S_FIN: begin
                    finish <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_star_softmax_ctrl.sv
// Self-checking bench for star_softmax_ctrl (INPUT_LEN=4, LUT_LEN=8, NUM_ROWS=3, SUM_W=2).
module tb_star_softmax_ctrl;
  import star_pkg::*;

  localparam int DATA_W = 8, INPUT_LEN = 4, LUT_LEN = 8, NUM_ROWS = 3, ADDR_W = 9, SUM_W = 2;
  localparam int W = LUT_LEN + LUT_LEN*SUM_W;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic            mode;
    logic [7:0]      exp_max;
  } row_t;

  logic clk = 1'b0, reset, start;
  logic data_req, data_vld, cam_req, cam_ack, sub_req, sub_ack, mv_vld, mv_rdy;
  logic row_done, busy, finish;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data, xi;
  logic [LUT_LEN-1:0] i_xi_MV, o_xmax_MV, o_xi_MV, i_sub_MV, o_sub_MV;
  logic [LUT_LEN*SUM_W-1:0] o_sum_MV;
  state_t dbg_state;

  star_softmax_ctrl #(.DATA_W(DATA_W), .INPUT_LEN(INPUT_LEN), .LUT_LEN(LUT_LEN),
    .NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .data_req(data_req), .data_addr(data_addr), .data_vld(data_vld), .data(data),
    .cam_req(cam_req), .xi(xi), .cam_ack(cam_ack), .i_xi_MV(i_xi_MV),
    .sub_req(sub_req), .o_xmax_MV(o_xmax_MV), .o_xi_MV(o_xi_MV), .sub_ack(sub_ack), .i_sub_MV(i_sub_MV),
    .mv_vld(mv_vld), .mv_rdy(mv_rdy), .o_sub_MV(o_sub_MV), .o_sum_MV(o_sum_MV),
    .row_done(row_done), .busy(busy), .finish(finish), .dbg_state(dbg_state));

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0, n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] mem [512];
  row_t tbl [6];
  row_t run_rows [3];
  int max_dly = 0, rows_done = 0, cam_row = 0, cam_k = 0, sub_row = 0, sub_k = 0;
  bit rdy_rand = 0, spur_en = 0, prev_rd = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [7:0] therm(input logic [7:0] x);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i] = (int'(x) > i);
    return m;
  endfunction

  function automatic logic [7:0] sub_fn(input logic mode, input logic [7:0] xmax, input logic [7:0] xv);
    return mode ? (xmax & ~xv) : 8'h01;
  endfunction

  // reference model: push the four expected beats of one row
  task automatic model_row(input row_t r, output logic [7:0] mx);
    logic [7:0] mv [4];
    logic [7:0] sb [4];
    logic [LUT_LEN*SUM_W-1:0] sum;
    int c;
    mx = '0;
    for (int k = 0; k < 4; k++) begin
      mv[k] = therm(r.d[k]);
      if (mv[k] > mx) mx = mv[k];
    end
    for (int k = 0; k < 4; k++) sb[k] = sub_fn(r.mode, mx, mv[k]);
    sum = '0;
    for (int j = 0; j < LUT_LEN; j++) begin
      c = 0;
      for (int k = 0; k < 4; k++) c += int'(sb[k][j]);
`ifdef STAR_SUM_SAT_EN
      if (c > 3) c = 3;
`endif
      sum[j*SUM_W +: SUM_W] = 2'(c);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back({sb[k], sum});
  endtask

  // data memory responder
  initial begin : data_resp
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        data_vld = 1'b0; dly = 0;
      end else if (data_vld) begin
        data_vld = 1'b0;
      end else if (data_req) begin
        chk("data_addr", 64'(data_addr), 64'(exp_addr));
        if (dly == 0) begin
          data = mem[data_addr]; data_vld = 1'b1;
          exp_addr = exp_addr + 9'd1;
          dly = $urandom_range(0, max_dly);
        end else dly--;
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        data = 8'hEE; data_vld = 1'b1;
      end
    end
  end

  // CAM responder
  initial begin : cam_resp
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cam_ack = 1'b0; dly = 0;
      end else if (cam_ack) begin
        cam_ack = 1'b0;
      end else if (cam_req) begin
        if (cam_row >= 3) fail_msg("cam_extra_request");
        else begin
          chk("cam_xi", 64'(xi), 64'(run_rows[cam_row].d[cam_k]));
          if (dly == 0) begin
            i_xi_MV = therm(xi); cam_ack = 1'b1;
            dly = $urandom_range(0, max_dly);
            if (cam_k == 3) begin cam_k = 0; cam_row++; end else cam_k++;
          end else dly--;
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        i_xi_MV = 8'hA5; cam_ack = 1'b1;
      end
    end
  end

  // subtract responder
  initial begin : sub_resp
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sub_ack = 1'b0; dly = 0;
      end else if (sub_ack) begin
        sub_ack = 1'b0;
      end else if (sub_req) begin
        if (sub_row >= 3) fail_msg("sub_extra_request");
        else begin
          chk("sub_xmax", 64'(o_xmax_MV), 64'(run_rows[sub_row].exp_max));
          chk("sub_xi", 64'(o_xi_MV), 64'(therm(run_rows[sub_row].d[sub_k])));
          if (dly == 0) begin
            i_sub_MV = sub_fn(run_rows[sub_row].mode, o_xmax_MV, o_xi_MV); sub_ack = 1'b1;
            dly = $urandom_range(0, max_dly);
            if (sub_k == 3) begin sub_k = 0; sub_row++; end else sub_k++;
          end else dly--;
        end
      end else begin
        if (data_req || cam_req || mv_vld) chk("sub_ops_idle", 64'({o_xmax_MV, o_xi_MV}), 64'd0);
        if (spur_en && $urandom_range(0, 3) == 0) begin
          i_sub_MV = 8'h5A; sub_ack = 1'b1;
        end
      end
    end
  end

  // beat scoreboard and row_done monitor
  initial begin : beat_mon
    forever begin
      @(negedge clk);
      if (!reset) begin
        mv_rdy = 1'b0; prev_rd = 1'b0;
      end else begin
        mv_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (row_done) begin
          chk("row_done_pulse", 64'(prev_rd), 64'd0);
          rows_done++;
        end
        prev_rd = row_done;
        if (mv_vld) begin
          if (exp_q.size() == 0) fail_msg("beat_unexpected");
          else begin
            chk("beat", 64'({o_sub_MV, o_sum_MV}), 64'(exp_q[0]));
            if (mv_rdy) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_req"}, 64'(data_req), 0);
    chk({tag, "_data_addr"}, 64'(data_addr), 0);
    chk({tag, "_cam_req"}, 64'(cam_req), 0);
    chk({tag, "_xi"}, 64'(xi), 0);
    chk({tag, "_sub_req"}, 64'(sub_req), 0);
    chk({tag, "_sub_ops"}, 64'({o_xmax_MV, o_xi_MV}), 0);
    chk({tag, "_mv_vld"}, 64'(mv_vld), 0);
    chk({tag, "_beat_payload"}, 64'({o_sub_MV, o_sum_MV}), 0);
    chk({tag, "_flags"}, 64'({row_done, busy, finish}), 0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); check_reset_outputs("rst");
    exp_q.delete();
    exp_addr = '0; cam_row = 0; cam_k = 0; sub_row = 0; sub_k = 0; rows_done = 0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic prepare_rows(input bit use_model_max);
    logic [7:0] mx;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) mem[r*4 + k] = run_rows[r].d[k];
      model_row(run_rows[r], mx);
      if (use_model_max) run_rows[r].exp_max = mx;
    end
  endtask

  task automatic do_run(input bit use_model_max, input bit mid_start);
    int cyc;
    prepare_rows(use_model_max);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!finish && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = (mid_start && cyc == 20);
      if (mid_start && cyc == 20) chk("busy_mid_run", 64'(busy), 1);
    end
    start = 1'b0;
    if (!finish) fail_msg("run_timeout");
    else begin
      chk("rows_done", 64'(rows_done), 3);
      chk("beats_left", 64'(exp_q.size()), 0);
      chk("addr_end", 64'(data_addr), 64'(3*INPUT_LEN));
      chk("busy_in_fin", 64'(busy), 0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      chk("fin_holds", 64'({finish, busy, data_req}), 64'(3'b100));
      chk("fin_state", 64'(dbg_state), 64'(S_FIN));
    end
  endtask

  initial begin : main
    int cyc;
    tbl[0] = '{d: {8'd4, 8'd3, 8'd2, 8'd1}, mode: 1'b0, exp_max: 8'h0F};
    tbl[1] = '{d: {8'd3, 8'd2, 8'd3, 8'd1}, mode: 1'b1, exp_max: 8'h07};
    tbl[2] = '{d: {8'd2, 8'd8, 8'd0, 8'd4}, mode: 1'b1, exp_max: 8'hFF};
    tbl[3] = '{d: {8'd5, 8'd5, 8'd5, 8'd5}, mode: 1'b0, exp_max: 8'h1F};
    tbl[4] = '{d: {8'd0, 8'd0, 8'd0, 8'd0}, mode: 1'b1, exp_max: 8'h00};
    tbl[5] = '{d: {8'd1, 8'd7, 8'd6, 8'd7}, mode: 1'b1, exp_max: 8'h7F};
    for (int i = 0; i < 512; i++) mem[i] = '0;
    reset = 1'b0; start = 1'b0; data = '0; data_vld = 1'b0; cam_ack = 1'b0; i_xi_MV = '0;
    sub_ack = 1'b0; i_sub_MV = '0; mv_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_without_start", 64'({busy, data_req}), 0);

    // zero-latency run over table rows 0..2
    for (int r = 0; r < 3; r++) run_rows[r] = tbl[r];
    do_run(1'b0, 1'b0);

    // same rows with random stalls, spurious acks and a start pulse while busy
    apply_reset();
    max_dly = 5; rdy_rand = 1; spur_en = 1;
    for (int r = 0; r < 3; r++) run_rows[r] = tbl[r];
    do_run(1'b0, 1'b1);

    // tied maxima rows, aborted by reset during the first EMIT
    apply_reset();
    max_dly = 0; rdy_rand = 0; spur_en = 0;
    for (int r = 0; r < 3; r++) run_rows[r] = tbl[r + 3];
    prepare_rows(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!mv_vld && cyc < 500) begin @(negedge clk); cyc++; end
    if (!mv_vld) fail_msg("emit_timeout");
    apply_reset();

    // clean run of random rows from address 0
    max_dly = 3; rdy_rand = 1; spur_en = 1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) run_rows[r].d[k] = 8'($urandom_range(0, 9));
      run_rows[r].mode = 1'($urandom_range(0, 1));
      run_rows[r].exp_max = '0;
    end
    do_run(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/star_softmax_ctrl.md
Name: star_softmax_ctrl

Overview:
Parametrised successor of the STAR row controller for CAM/LUT softmax. Processes NUM_ROWS rows of INPUT_LEN elements each. Per row: load the row, fetch a match vector per element from the CAM, find the max vector, and request a subtracted vector per element. It then accumulates per-LUT-entry hit counts and streams (sub vector, sum counts) to the LUT stage. All memory-side transfers use req/ack or valid/ready handshakes, so stalls are tolerated instead of relying on fixed latencies.

Parameters:
DATA_W, 8, input element width
INPUT_LEN, 16, elements per row (>=2)
LUT_LEN, 64, match-vector width
NUM_ROWS, 16, rows per run
ADDR_W, 9, input memory address width
SUM_W, 3, per-entry hit counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse in IDLE begins a run
data_req  out  1  input read request
data_addr  out  ADDR_W  input read address
data_vld  in  1  data valid; completes the pending read
data  in  DATA_W  input element
cam_req  out  1  CAM lookup request
xi  out  DATA_W  element presented to the CAM
cam_ack  in  1  CAM done; i_xi_MV valid
i_xi_MV  in  LUT_LEN  match vector of xi
sub_req  out  1  subtract request
o_xmax_MV  out  LUT_LEN  row max vector
o_xi_MV  out  LUT_LEN  element vector
sub_ack  in  1  subtract done; i_sub_MV valid
i_sub_MV  in  LUT_LEN  subtracted vector
mv_vld  out  1  output beat valid
mv_rdy  in  1  LUT stage ready
o_sub_MV  out  LUT_LEN  stored sub vector for element k
o_sum_MV  out  LUT_LEN*SUM_W  per-entry counts; entry j at bits [j*SUM_W +: SUM_W]
row_done  out  1  one-cycle pulse after a row's last beat
busy  out  1  high in every state except IDLE and FIN
finish  out  1  level, high in FIN

Behaviour:
- Reset (reset==0, async) puts the FSM in IDLE and clears all counters, buffers and vector arrays. Every output is 0, including data_addr.
- States: IDLE -> LOAD -> CAMSUB -> FINDMAX -> FINDSUB -> ACCUM -> EMIT -> (LOAD | FIN).
  - IDLE leaves only on start.
  - FIN holds until reset; start is ignored in FIN and in all busy states.
- Element index k runs 0..INPUT_LEN-1.
- LUT stage handshake: a beat transfers when mv_vld && mv_rdy. mv_vld and the beat's payload are held stable until the transfer.
- Memory-side request handshake:
  - Each *_req is held high until its ack/vld. The cycle after ack, the req drops for at least one cycle.
  - Address and operands are stable while req is high.
  - An ack arriving without a req is ignored.
- LOAD: data_addr increments by 1 on each data_vld and carries across rows (row r starts at r*INPUT_LEN). It wraps modulo 2^ADDR_W. data is stored at buf[k].
- CAMSUB: xi=buf[k]. On cam_ack, MV[k]<=i_xi_MV.
- FINDMAX: one element per cycle, INPUT_LEN cycles. max is the unsigned-largest MV[k]; on a tie the earlier index is kept. No handshake.
- FINDSUB: o_xmax_MV=max and o_xi_MV=MV[k] while sub_req is high. On sub_ack, MV[k]<=i_sub_MV. Both outputs are 0 outside FINDSUB.
- ACCUM: single cycle. cnt[j] = popcount over k of MV[k][j], truncated to SUM_W bits (see option).
- EMIT: INPUT_LEN beats, o_sub_MV=MV[k], o_sum_MV=cnt. After the last beat transfers, row_done pulses and row_cnt increments.
  - If row_cnt==NUM_ROWS after the increment, the FSM goes to FIN; otherwise it goes to LOAD.
- finish rises in the cycle after the last row's row_done.
- Counts are cleared on entering CAMSUB for each row. No state from row r leaks into row r+1.
- Reset mid-operation aborts immediately. Any partially transferred beat is discarded.

Optional Feature:
STAR_SUM_SAT_EN
- Defined: each cnt[j] saturates at 2^SUM_W-1.
- Undefined: each cnt[j] wraps modulo 2^SUM_W.

Decomposition:
- Package star_pkg: FSM state enum, localparam CNT_W=$clog2(INPUT_LEN+1), ROW_W=$clog2(NUM_ROWS+1).
- Sub-module star_col_counter: LUT_LEN x INPUT_LEN column popcount with width truncation/saturation. Purely combinational, used by ACCUM.

Test Plan:
- INPUT_LEN=4, NUM_ROWS=1, all acks immediate; data 1,2,3,4; CAM returns thermometer vectors 0x1,0x3,0x7,0xF -> o_xmax_MV=0xF on every FINDSUB request; 4 EMIT beats; row_done; finish high.
- Same row with sub vectors all 0x1 -> cnt[0]=4 and others 0. SUM_W=2 gives cnt[0]=3 with STAR_SUM_SAT_EN and 0 without.
- Random 0-5 cycle delays on data_vld/cam_ack/sub_ack and random mv_rdy -> identical beat sequence to the zero-delay run; req/payload stable while waiting.
- NUM_ROWS=3 -> data_addr reaches 3*INPUT_LEN; 3 row_done pulses; row 2 counts unaffected by row 1.
- Tied max vectors 0x7 at k=1 and k=3 -> o_xmax_MV=0x7; start asserted while busy is ignored.
- reset asserted mid-EMIT -> all outputs 0 next edge; new start runs a clean row from data_addr 0.
